// File: rtl/stack_cpu_gen2_pkg.sv
// Shared types and constants for the second-generation stack CPU.
// Instruction word: {opcode[4:0], reserved 1'b0, imm}.
package stack_cpu_gen2_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_STACK_DEPTH  = 8;
  localparam int DEF_INSTR_WIDTH  = 16;
  localparam int DEF_PC_WIDTH     = 8;
  localparam int DEF_SSTEP_ENABLE = 0;

  // Opcode sits in the top OPC_W bits; the reserved bit is at INSTR_WIDTH-RSVD_OFS.
  localparam int OPC_W    = 5;
  localparam int RSVD_OFS = 6;

  typedef enum logic [4:0] {
    OP_NOP   = 5'd0,
    OP_PUSHI = 5'd1,
    OP_POP   = 5'd2,
    OP_DUP   = 5'd3,
    OP_SWAP  = 5'd4,
    OP_ADD   = 5'd5,
    OP_SUB   = 5'd6,
    OP_MUL   = 5'd7,
    OP_DIV   = 5'd8,
    OP_JMP   = 5'd9,
    OP_JZ    = 5'd10,
    OP_HALT  = 5'd31
  } opcode_t;

  typedef enum logic [1:0] {
    ST_FETCH     = 2'd0,
    ST_EXEC      = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_HALTED    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_OVERFLOW  = 2'd1,
    ERR_UNDERFLOW = 2'd2,
    ERR_DIVZ_ILL  = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    STK_NONE      = 3'd0,
    STK_PUSH      = 3'd1,
    STK_POP       = 3'd2,
    STK_POP2_PUSH = 3'd3,
    STK_SWAP      = 3'd4
  } stk_op_t;

endpackage

// File: rtl/stack_cpu_gen2_stack.sv
// Register-array operand stack with single-cycle push, pop, pop2-push and swap.
// Entry storage is intentionally not reset; only the pointer is.
module stack_cpu_gen2_stack
  import stack_cpu_gen2_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  stk_op_t                          op,
  input  logic signed [DATA_WIDTH-1:0]     wdata,
  output logic signed [DATA_WIDTH-1:0]     tos,
  output logic signed [DATA_WIDTH-1:0]     nos,
  output logic [$clog2(STACK_DEPTH):0]     depth,
  output logic                             full,
  output logic                             empty,
  output logic                             ge2
);
  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] ONE_D = (AW+1)'(1);

  logic signed [DATA_WIDTH-1:0] mem_r [STACK_DEPTH];
  logic [AW:0]   sp_r;
  logic [AW-1:0] push_idx_s;
  logic [AW-1:0] top_idx_s;
  logic [AW-1:0] nos_idx_s;

  assign push_idx_s = sp_r[AW-1:0];
  assign top_idx_s  = push_idx_s - AW'(1);
  assign nos_idx_s  = push_idx_s - AW'(2);
  assign tos        = mem_r[top_idx_s];
  assign nos        = mem_r[nos_idx_s];
  assign depth      = sp_r;
  // Depth is a power of two and sp never exceeds it, so the MSB alone means full.
  assign full       = sp_r[AW];
  assign empty      = (sp_r == '0);
  assign ge2        = (sp_r > ONE_D);

  // Stack pointer / entry count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_r <= '0;
    end else begin
      case (op)
        STK_PUSH:               sp_r <= sp_r + ONE_D;
        STK_POP, STK_POP2_PUSH: sp_r <= sp_r - ONE_D;
        default:                sp_r <= sp_r;
      endcase
    end
  end

  // Entry storage writes.
  always_ff @(posedge clk) begin
    case (op)
      STK_PUSH:      mem_r[push_idx_s] <= wdata;
      STK_POP2_PUSH: mem_r[nos_idx_s]  <= wdata;
      STK_SWAP: begin
        mem_r[top_idx_s] <= nos;
        mem_r[nos_idx_s] <= tos;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/stack_cpu_gen2.sv
// Second-generation stack CPU: FETCH/EXEC control FSM, ALU and coded error report.
// Define STACK_CPU_SAT_EN to make ADD/SUB/MUL (and MIN/-1) saturate instead of wrap.
module stack_cpu_gen2
  import stack_cpu_gen2_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int STACK_DEPTH  = DEF_STACK_DEPTH,
  parameter int INSTR_WIDTH  = DEF_INSTR_WIDTH,
  parameter int PC_WIDTH     = DEF_PC_WIDTH,
  parameter int SSTEP_ENABLE = DEF_SSTEP_ENABLE
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [INSTR_WIDTH-1:0]        instruction,
  output logic [PC_WIDTH-1:0]           pc,
  input  logic                          single_step,
  output logic signed [DATA_WIDTH-1:0]  result,
  output logic                          valid_result,
  output logic [$clog2(STACK_DEPTH):0]  depth,
  output logic                          error,
  output logic [1:0]                    error_code,
  output logic                          halt
);
  localparam int IMM_W = INSTR_WIDTH - RSVD_OFS;
  localparam logic signed [DATA_WIDTH-1:0] MIN_V = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t                       state_r;
  err_code_t                    code_r;
  logic [INSTR_WIDTH-1:0]       ir_r;
  logic [PC_WIDTH-1:0]          pc_r;
  logic                         valid_r, err_r, halt_r, ss_prev_r;

  logic [OPC_W-1:0]             opc_s;
  logic [IMM_W-1:0]             imm_s;
  logic signed [DATA_WIDTH-1:0] imm_ext_s, tos_s, nos_s, wdata_s;
  logic signed [DATA_WIDTH-1:0] add_s, sub_s, mul_s, quot_s, alu_s;
  logic                         full_s, empty_s, ge2_s, exec_halt_s, pushed_s;
  stk_op_t                      stk_op_s, stk_op_q_s;
  err_code_t                    exec_code_s;
  logic [PC_WIDTH-1:0]          pc_next_s;

  assign opc_s     = ir_r[INSTR_WIDTH-1 -: OPC_W];
  assign imm_s     = ir_r[IMM_W-1:0];
  assign imm_ext_s = {{(DATA_WIDTH-IMM_W){imm_s[IMM_W-1]}}, imm_s};

  stack_cpu_gen2_stack #(
    .DATA_WIDTH  (DATA_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (reset),
    .op    (stk_op_q_s),
    .wdata (wdata_s),
    .tos   (tos_s),
    .nos   (nos_s),
    .depth (depth),
    .full  (full_s),
    .empty (empty_s),
    .ge2   (ge2_s)
  );

`ifdef STACK_CPU_SAT_EN
  localparam logic signed [DATA_WIDTH-1:0] MAX_V = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  logic [DATA_WIDTH:0]     sum_s, diff_s, prod_hi_s;
  logic [2*DATA_WIDTH-1:0] prod_s;

  // Saturating arithmetic: overflow shows as disagreement among the top result bits.
  always_comb begin
    sum_s     = {nos_s[DATA_WIDTH-1], nos_s} + {tos_s[DATA_WIDTH-1], tos_s};
    diff_s    = {nos_s[DATA_WIDTH-1], nos_s} - {tos_s[DATA_WIDTH-1], tos_s};
    prod_s    = {{DATA_WIDTH{nos_s[DATA_WIDTH-1]}}, nos_s} * {{DATA_WIDTH{tos_s[DATA_WIDTH-1]}}, tos_s};
    prod_hi_s = prod_s[2*DATA_WIDTH-1:DATA_WIDTH-1];
    if (sum_s[DATA_WIDTH] != sum_s[DATA_WIDTH-1]) add_s = sum_s[DATA_WIDTH] ? MIN_V : MAX_V;
    else                                          add_s = sum_s[DATA_WIDTH-1:0];
    if (diff_s[DATA_WIDTH] != diff_s[DATA_WIDTH-1]) sub_s = diff_s[DATA_WIDTH] ? MIN_V : MAX_V;
    else                                            sub_s = diff_s[DATA_WIDTH-1:0];
    if (!((&prod_hi_s) || (~|prod_hi_s))) mul_s = prod_hi_s[DATA_WIDTH] ? MIN_V : MAX_V;
    else                                   mul_s = prod_s[DATA_WIDTH-1:0];
    if (tos_s == '0)                          quot_s = '0;
    else if (nos_s == MIN_V && tos_s == '1)   quot_s = MAX_V;
    else                                      quot_s = nos_s / tos_s;
  end
`else
  // Wrapping arithmetic keeps the low DATA_WIDTH bits.
  always_comb begin
    add_s = nos_s + tos_s;
    sub_s = nos_s - tos_s;
    mul_s = nos_s * tos_s;
    if (tos_s == '0)                          quot_s = '0;
    else if (nos_s == MIN_V && tos_s == '1)   quot_s = MIN_V;
    else                                      quot_s = nos_s / tos_s;
  end
`endif

  // ALU result select.
  always_comb begin
    case (opc_s)
      OP_SUB:  alu_s = sub_s;
      OP_MUL:  alu_s = mul_s;
      OP_DIV:  alu_s = quot_s;
      default: alu_s = add_s;
    endcase
  end

  // Instruction decode: operand checks, stack operation and next pc.
  always_comb begin
    stk_op_s    = STK_NONE;
    wdata_s     = alu_s;
    pc_next_s   = pc_r + PC_WIDTH'(1);
    exec_code_s = ERR_NONE;
    exec_halt_s = 1'b0;
    if (ir_r[INSTR_WIDTH-RSVD_OFS]) begin
      exec_code_s = ERR_DIVZ_ILL;
    end else begin
      case (opc_s)
        OP_NOP: ;
        OP_PUSHI: begin
          if (full_s) exec_code_s = ERR_OVERFLOW;
          else begin stk_op_s = STK_PUSH; wdata_s = imm_ext_s; end
        end
        OP_POP: begin
          if (empty_s) exec_code_s = ERR_UNDERFLOW;
          else         stk_op_s = STK_POP;
        end
        OP_DUP: begin
          if (empty_s)     exec_code_s = ERR_UNDERFLOW;
          else if (full_s) exec_code_s = ERR_OVERFLOW;
          else begin stk_op_s = STK_PUSH; wdata_s = tos_s; end
        end
        OP_SWAP: begin
          if (!ge2_s) exec_code_s = ERR_UNDERFLOW;
          else        stk_op_s = STK_SWAP;
        end
        OP_ADD, OP_SUB, OP_MUL: begin
          if (!ge2_s) exec_code_s = ERR_UNDERFLOW;
          else        stk_op_s = STK_POP2_PUSH;
        end
        OP_DIV: begin
          if (!ge2_s)            exec_code_s = ERR_UNDERFLOW;
          else if (tos_s == '0)  exec_code_s = ERR_DIVZ_ILL;
          else                   stk_op_s = STK_POP2_PUSH;
        end
        OP_JMP: pc_next_s = imm_s[PC_WIDTH-1:0];
        OP_JZ: begin
          if (empty_s) exec_code_s = ERR_UNDERFLOW;
          else begin
            stk_op_s = STK_POP;
            if (tos_s == '0) pc_next_s = imm_s[PC_WIDTH-1:0];
            else             pc_next_s = pc_r + PC_WIDTH'(1);
          end
        end
        OP_HALT: exec_halt_s = 1'b1;
        default: exec_code_s = ERR_DIVZ_ILL;
      endcase
    end
  end

  // Faulting instructions never reach the stack, so state is preserved on error.
  assign stk_op_q_s = (state_r == ST_EXEC && exec_code_s == ERR_NONE) ? stk_op_s : STK_NONE;
  assign pushed_s   = (stk_op_s == STK_PUSH) || (stk_op_s == STK_POP2_PUSH) || (stk_op_s == STK_SWAP);

  // Control FSM with registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= ST_FETCH;
      ir_r      <= '0;
      pc_r      <= '0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      code_r    <= ERR_NONE;
      halt_r    <= 1'b0;
      ss_prev_r <= 1'b0;
    end else begin
      ss_prev_r <= single_step;
      case (state_r)
        ST_FETCH: begin
          ir_r    <= instruction;
          valid_r <= 1'b0;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          if (exec_code_s != ERR_NONE) begin
            err_r   <= 1'b1;
            code_r  <= exec_code_s;
            halt_r  <= 1'b1;
            valid_r <= 1'b0;
            state_r <= ST_HALTED;
          end else if (exec_halt_s) begin
            halt_r  <= 1'b1;
            valid_r <= 1'b0;
            state_r <= ST_HALTED;
          end else begin
            pc_r    <= pc_next_s;
            valid_r <= pushed_s;
            state_r <= (SSTEP_ENABLE != 0) ? ST_STEP_WAIT : ST_FETCH;
          end
        end
        ST_STEP_WAIT: begin
          valid_r <= 1'b0;
          if (single_step && !ss_prev_r) state_r <= ST_FETCH;
          else                           state_r <= ST_STEP_WAIT;
        end
        ST_HALTED: begin
          valid_r <= 1'b0;
          state_r <= ST_HALTED;
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ST_FETCH;
        end
      endcase
    end
  end

  assign pc           = pc_r;
  assign result       = empty_s ? '0 : tos_s;
  assign valid_result = valid_r;
  assign error        = err_r;
  assign error_code   = code_r;
  assign halt         = halt_r;

endmodule

// File: tb/tb_stack_cpu_gen2.sv
// Scoreboard bench for stack_cpu_gen2: a depth-4 free-running core and a single-step core.
module tb_stack_cpu_gen2;
  localparam logic [4:0] NOP = 5'd0, PUSHI = 5'd1, POP = 5'd2, DUP = 5'd3, SWAP = 5'd4,
                         ADD = 5'd5, SUB = 5'd6, MUL = 5'd7, DIV = 5'd8, JMP = 5'd9,
                         JZ = 5'd10, HLT = 5'd31;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic single_step = 1'b0;
  always #5 clk = ~clk;

  logic [15:0]        mem_a [256];
  logic [15:0]        instr_a;
  logic [7:0]         pc_a;
  logic signed [15:0] result_a;
  logic               valid_a, error_a, halt_a;
  logic [2:0]         depth_a;
  logic [1:0]         code_a;

  logic [15:0]        mem_b [256];
  logic [15:0]        instr_b;
  logic [7:0]         pc_b;
  logic signed [15:0] result_b;
  logic               valid_b, error_b, halt_b;
  logic [3:0]         depth_b;
  logic [1:0]         code_b;

  assign instr_a = mem_a[pc_a];
  assign instr_b = mem_b[pc_b];

  stack_cpu_gen2 #(.STACK_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .instruction(instr_a), .pc(pc_a), .single_step(1'b0),
    .result(result_a), .valid_result(valid_a), .depth(depth_a), .error(error_a),
    .error_code(code_a), .halt(halt_a)
  );

  stack_cpu_gen2 #(.SSTEP_ENABLE(1)) dut_ss (
    .clk(clk), .reset(reset), .instruction(instr_b), .pc(pc_b), .single_step(single_step),
    .result(result_b), .valid_result(valid_b), .depth(depth_b), .error(error_b),
    .error_code(code_b), .halt(halt_b)
  );

  int checks = 0;
  int errors = 0;
  logic signed [15:0] exp_q [$];

  function automatic logic [15:0] enc(input logic [4:0] op, input int imm);
    logic [9:0] i10;
    i10 = imm[9:0];
    return {op, 1'b0, i10};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = enc(HLT, 0);
      mem_b[i] = enc(HLT, 0);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Run the free-running core to halt, popping the scoreboard on every valid pulse.
  task automatic run_a(input string name, input int budget);
    bit done = 1'b0;
    logic signed [15:0] e;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (valid_a) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL %s extra_valid got %0d want no pulse", name, result_a);
        end else begin
          e = exp_q.pop_front();
          if (result_a !== e) begin errors++; $display("FAIL %s result got %0d want %0d", name, result_a, e); end
        end
      end
      if (halt_a) done = 1'b1;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout got running want halt", name); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s missing_valid got %0d left want 0", name, exp_q.size()); end
  endtask

  task automatic ss_cycles(input int n);
    logic signed [15:0] e;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (valid_b) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL ss extra_valid got %0d want no pulse", result_b);
        end else begin
          e = exp_q.pop_front();
          if (result_b !== e) begin errors++; $display("FAIL ss result got %0d want %0d", result_b, e); end
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++; if (pc_a !== 8'd0)     begin errors++; $display("FAIL rst_pc got %0d want 0", pc_a); end
    checks++; if (depth_a !== 3'd0)  begin errors++; $display("FAIL rst_depth got %0d want 0", depth_a); end
    checks++; if (result_a !== 16'sd0) begin errors++; $display("FAIL rst_result got %0d want 0", result_a); end
    checks++; if ({valid_a, error_a, code_a, halt_a} !== 5'b0) begin
      errors++; $display("FAIL rst_status got %b want 00000", {valid_a, error_a, code_a, halt_a}); end
    checks++; if ({pc_b, depth_b, halt_b} !== 13'd0) begin
      errors++; $display("FAIL rst_ss got %h want 0", {pc_b, depth_b, halt_b}); end
  endtask

  task automatic test_arith();
    clear_mem();
    mem_a[0] = enc(PUSHI, 7); mem_a[1] = enc(PUSHI, -3); mem_a[2] = enc(ADD, 0);
    reset_dut();
    exp_q.push_back(16'sd7); exp_q.push_back(-16'sd3); exp_q.push_back(16'sd4);
    run_a("arith", 40);
    checks++; if (result_a !== 16'sd4) begin errors++; $display("FAIL arith_final got %0d want 4", result_a); end
    checks++; if (pc_a !== 8'd3)       begin errors++; $display("FAIL arith_pc got %0d want 3", pc_a); end
    checks++; if (halt_a !== 1'b1 || error_a !== 1'b0) begin
      errors++; $display("FAIL arith_halt got halt=%b err=%b want 1 0", halt_a, error_a); end
  endtask

  task automatic test_alu();
    clear_mem();
    mem_a[0] = enc(PUSHI, 10);  mem_a[1] = enc(PUSHI, 3);   mem_a[2] = enc(SUB, 0);
    mem_a[3] = enc(PUSHI, -7);  mem_a[4] = enc(PUSHI, 2);   mem_a[5] = enc(DIV, 0);
    mem_a[6] = enc(MUL, 0);     mem_a[7] = enc(PUSHI, -256); mem_a[8] = enc(PUSHI, 128);
    mem_a[9] = enc(MUL, 0);     mem_a[10] = enc(PUSHI, -1); mem_a[11] = enc(DIV, 0);
    mem_a[12] = enc(SWAP, 0);   mem_a[13] = enc(DUP, 0);    mem_a[14] = enc(POP, 0);
    reset_dut();
    exp_q.push_back(16'sd10); exp_q.push_back(16'sd3); exp_q.push_back(16'sd7);
    exp_q.push_back(-16'sd7); exp_q.push_back(16'sd2); exp_q.push_back(-16'sd3);
    exp_q.push_back(-16'sd21); exp_q.push_back(-16'sd256); exp_q.push_back(16'sd128);
    exp_q.push_back(-16'sd32768); exp_q.push_back(-16'sd1);
`ifdef STACK_CPU_SAT_EN
    exp_q.push_back(16'sd32767);
`else
    exp_q.push_back(-16'sd32768);
`endif
    exp_q.push_back(-16'sd21); exp_q.push_back(-16'sd21);
    run_a("alu", 80);
    checks++; if (depth_a !== 3'd2 || result_a !== -16'sd21) begin
      errors++; $display("FAIL alu_final got depth=%0d res=%0d want 2 -21", depth_a, result_a); end
    checks++; if (pc_a !== 8'd15) begin errors++; $display("FAIL alu_pc got %0d want 15", pc_a); end
  endtask

  task automatic test_overflow();
    clear_mem();
    mem_a[0] = enc(PUSHI, 256); mem_a[1] = enc(PUSHI, 128); mem_a[2] = enc(MUL, 0);
    mem_a[3] = enc(PUSHI, 1);   mem_a[4] = enc(SUB, 0);     mem_a[5] = enc(PUSHI, 1);
    mem_a[6] = enc(ADD, 0);     mem_a[7] = enc(PUSHI, 1);   mem_a[8] = enc(ADD, 0);
    reset_dut();
    exp_q.push_back(16'sd256); exp_q.push_back(16'sd128);
`ifdef STACK_CPU_SAT_EN
    exp_q.push_back(16'sd32767); exp_q.push_back(16'sd1); exp_q.push_back(16'sd32766);
    exp_q.push_back(16'sd1); exp_q.push_back(16'sd32767); exp_q.push_back(16'sd1); exp_q.push_back(16'sd32767);
`else
    exp_q.push_back(-16'sd32768); exp_q.push_back(16'sd1); exp_q.push_back(16'sd32767);
    exp_q.push_back(16'sd1); exp_q.push_back(-16'sd32768); exp_q.push_back(16'sd1); exp_q.push_back(-16'sd32767);
`endif
    run_a("ovf", 60);
    checks++; if (error_a !== 1'b0 || code_a !== 2'd0) begin
      errors++; $display("FAIL ovf_noerr got err=%b code=%0d want 0 0", error_a, code_a); end
  endtask

  task automatic test_divzero();
    clear_mem();
    mem_a[0] = enc(PUSHI, 5); mem_a[1] = enc(PUSHI, 0); mem_a[2] = enc(DIV, 0);
    reset_dut();
    exp_q.push_back(16'sd5); exp_q.push_back(16'sd0);
    run_a("divz", 40);
    checks++; if (error_a !== 1'b1 || code_a !== 2'd3) begin
      errors++; $display("FAIL divz_code got err=%b code=%0d want 1 3", error_a, code_a); end
    checks++; if (depth_a !== 3'd2 || result_a !== 16'sd0 || pc_a !== 8'd2) begin
      errors++; $display("FAIL divz_state got depth=%0d res=%0d pc=%0d want 2 0 2", depth_a, result_a, pc_a); end
  endtask

  task automatic test_stack_errors();
    clear_mem();
    for (int i = 0; i < 5; i++) mem_a[i] = enc(PUSHI, i + 1);
    reset_dut();
    for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
    run_a("full", 60);
    checks++; if (error_a !== 1'b1 || code_a !== 2'd1) begin
      errors++; $display("FAIL full_code got err=%b code=%0d want 1 1", error_a, code_a); end
    checks++; if (depth_a !== 3'd4 || pc_a !== 8'd4 || result_a !== 16'sd4) begin
      errors++; $display("FAIL full_state got depth=%0d pc=%0d res=%0d want 4 4 4", depth_a, pc_a, result_a); end
    clear_mem();
    mem_a[0] = enc(ADD, 0);
    reset_dut();
    run_a("empty", 20);
    checks++; if (code_a !== 2'd2 || depth_a !== 3'd0 || pc_a !== 8'd0) begin
      errors++; $display("FAIL empty_add got code=%0d depth=%0d pc=%0d want 2 0 0", code_a, depth_a, pc_a); end
    clear_mem();
    mem_a[0] = enc(PUSHI, 9); mem_a[1] = enc(5'd12, 0);
    reset_dut();
    exp_q.push_back(16'sd9);
    run_a("illegal", 20);
    checks++; if (code_a !== 2'd3 || depth_a !== 3'd1 || pc_a !== 8'd1) begin
      errors++; $display("FAIL illegal got code=%0d depth=%0d pc=%0d want 3 1 1", code_a, depth_a, pc_a); end
  endtask

  task automatic test_branch();
    clear_mem();
    mem_a[0] = enc(PUSHI, 0); mem_a[1] = enc(JZ, 20); mem_a[2] = enc(NOP, 0);
    reset_dut();
    exp_q.push_back(16'sd0);
    run_a("jz_taken", 30);
    checks++; if (pc_a !== 8'd20 || depth_a !== 3'd0) begin
      errors++; $display("FAIL jz_taken got pc=%0d depth=%0d want 20 0", pc_a, depth_a); end
    clear_mem();
    mem_a[0] = enc(PUSHI, 1); mem_a[1] = enc(JZ, 20);
    reset_dut();
    exp_q.push_back(16'sd1);
    run_a("jz_not", 30);
    checks++; if (pc_a !== 8'd2 || depth_a !== 3'd0 || error_a !== 1'b0) begin
      errors++; $display("FAIL jz_not got pc=%0d depth=%0d err=%b want 2 0 0", pc_a, depth_a, error_a); end
  endtask

  task automatic test_wrap();
    clear_mem();
    mem_a[0] = enc(JMP, 255); mem_a[255] = enc(NOP, 0);
    reset_dut();
    repeat (2) @(negedge clk);
    checks++; if (pc_a !== 8'd255) begin errors++; $display("FAIL jmp_pc got %0d want 255", pc_a); end
    repeat (2) @(negedge clk);
    checks++; if (pc_a !== 8'd0) begin errors++; $display("FAIL wrap_pc got %0d want 0", pc_a); end
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem_a[0] = enc(PUSHI, 7); mem_a[1] = enc(PUSHI, 8);
    reset_dut();
    repeat (2) @(negedge clk);
    checks++; if (valid_a !== 1'b1 || result_a !== 16'sd7) begin
      errors++; $display("FAIL mid_pre got valid=%b res=%0d want 1 7", valid_a, result_a); end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if ({pc_a, depth_a, valid_a, error_a, code_a, halt_a} !== 16'd0 || result_a !== 16'sd0) begin
      errors++; $display("FAIL mid_reset got pc=%0d depth=%0d res=%0d valid=%b want all 0", pc_a, depth_a, result_a, valid_a); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single_step();
    clear_mem();
    mem_b[0] = enc(PUSHI, 3); mem_b[1] = enc(PUSHI, 4); mem_b[2] = enc(ADD, 0);
    single_step = 1'b0;
    reset_dut();
    exp_q.push_back(16'sd3);
    ss_cycles(6);
    checks++; if (pc_b !== 8'd1 || depth_b !== 4'd1) begin
      errors++; $display("FAIL ss_hold got pc=%0d depth=%0d want 1 1", pc_b, depth_b); end
    single_step = 1'b1;
    exp_q.push_back(16'sd4);
    ss_cycles(8);
    checks++; if (pc_b !== 8'd2 || exp_q.size() != 0) begin
      errors++; $display("FAIL ss_once got pc=%0d pending=%0d want 2 0", pc_b, exp_q.size()); end
    single_step = 1'b0;
    ss_cycles(2);
    single_step = 1'b1;
    exp_q.push_back(16'sd7);
    ss_cycles(4);
    checks++; if (pc_b !== 8'd3 || result_b !== 16'sd7 || exp_q.size() != 0) begin
      errors++; $display("FAIL ss_add got pc=%0d res=%0d want 3 7", pc_b, result_b); end
    single_step = 1'b0;
    ss_cycles(2);
    single_step = 1'b1;
    ss_cycles(4);
    checks++; if (halt_b !== 1'b1 || error_b !== 1'b0 || pc_b !== 8'd3) begin
      errors++; $display("FAIL ss_halt got halt=%b err=%b pc=%0d want 1 0 3", halt_b, error_b, pc_b); end
    single_step = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_alu();
    test_overflow();
    test_divzero();
    test_stack_errors();
    test_branch();
    test_wrap();
    test_reset_mid();
    test_single_step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
